// File: rtl/run_ctrl_pkg.sv
// Shared run-control definitions: FSM state encoding and the default halt opcode
// (kept in step with the decode stage's opcode table).
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4,
    ST_TIMEOUT = 3'd5
  } run_state_e;

  localparam logic [5:0] HALT_OPCODE_DEF = 6'h11;

  // The processor is out of reset only while a run is executing or draining.
  function automatic logic is_active(run_state_e s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/run_controller_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/run_controller.sv
// Run controller: holds the processor in reset, releases it for a run, counts cycles and
// retires, and ends the run on a retired halt opcode (after a drain window) or a watchdog timeout.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int                  OPCODE_W       = 6,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE    = OPCODE_W'(HALT_OPCODE_DEF),
  parameter int                  RESET_CYCLES   = 2,
  parameter int                  DRAIN_CYCLES   = 4,
  parameter int                  TIMEOUT_CYCLES = 100000,
  parameter int                  CNT_W          = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                wb_valid,
  input  logic [OPCODE_W-1:0] wb_opcode,
  output logic                cpu_reset,
  output logic                running,
  output logic                done,
  output logic                timed_out,
  output logic [CNT_W-1:0]    cycle_count,
  output logic [CNT_W-1:0]    retired_count,
  output logic [2:0]          state
);

  // Terminal values of the shared timer, compared at 64 bits so a timeout larger than the
  // counter range simply never fires instead of aliasing onto a truncated value.
  localparam logic [63:0] HOLD_LAST  = 64'(RESET_CYCLES - 1);
  localparam logic [63:0] DRAIN_LAST = 64'(DRAIN_CYCLES - 1);
  localparam logic [63:0] TO_LAST    = 64'(TIMEOUT_CYCLES - 1);

  run_state_e       state_q, state_d;
  logic             accept_start;
  logic             halt_seen;
  logic             timer_clr;
  logic             timer_inc;
  logic [CNT_W-1:0] timer;
  logic [63:0]      timer_w;
  logic             cpu_reset_q, running_q, done_q, timed_out_q;

  assign halt_seen = wb_valid && (wb_opcode == HALT_OPCODE);
  assign timer_w   = 64'(timer);

  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        if (start) begin
          state_d      = ST_HOLD;
          accept_start = 1'b1;
        end
      end
      ST_HOLD: begin
        if (timer_w == HOLD_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        // A halt retiring on the watchdog's last cycle still counts as a clean finish.
        if (halt_seen) begin
          state_d = (DRAIN_CYCLES > 0) ? ST_DRAIN : ST_DONE;
        end else if ((TIMEOUT_CYCLES > 0) && (timer_w == TO_LAST)) begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_DRAIN: begin
        if (timer_w == DRAIN_LAST) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cpu_reset_q <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpu_reset_q <= !is_active(state_d);
      running_q   <= is_active(state_d);
      done_q      <= (state_d == ST_DONE);
      timed_out_q <= (state_d == ST_TIMEOUT);
    end
  end

  // One timer serves HOLD length, the RUN watchdog and the DRAIN window; it restarts on every state change.
  assign timer_clr = (state_d != state_q);
  assign timer_inc = (state_q == ST_HOLD) || is_active(state_q);

  sat_counter #(.WIDTH(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (timer_clr),
    .inc   (timer_inc),
    .count (timer)
  );

  sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (accept_start),
    .inc   (is_active(state_q)),
    .count (cycle_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (accept_start),
    .inc   (is_active(state_q) && wb_valid),
    .count (retired_count)
  );

  assign cpu_reset = cpu_reset_q;
  assign running   = running_q;
  assign done      = done_q;
  assign timed_out = timed_out_q;
  assign state     = state_q;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: three configurations share one stimulus stream and are compared
// every cycle against a phase/age reference model, plus directed checks of the key scenarios.
module tb_run_controller;

  localparam logic [5:0] HALT = 6'h11;

  // Configurations: A = defaults, B = short watchdog, C = narrow counters, 1-cycle hold, no drain.
  int cfg_r [3] = '{2, 2, 1};
  int cfg_d [3] = '{4, 4, 0};
  int cfg_to[3] = '{100000, 20, 100000};
  int cfg_w [3] = '{32, 32, 4};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       wb_valid = 1'b0;
  logic [5:0] wb_opcode = 6'h00;

  logic        a_cr, a_run, a_done, a_to;
  logic [31:0] a_cyc, a_ret;
  logic [2:0]  a_state;
  logic        b_cr, b_run, b_done, b_to;
  logic [31:0] b_cyc, b_ret;
  logic [2:0]  b_state;
  logic        c_cr, c_run, c_done, c_to;
  logic [3:0]  c_cyc, c_ret;
  logic [2:0]  c_state;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  run_controller dut_a (
    .clk(clk), .reset(reset), .start(start), .wb_valid(wb_valid), .wb_opcode(wb_opcode),
    .cpu_reset(a_cr), .running(a_run), .done(a_done), .timed_out(a_to),
    .cycle_count(a_cyc), .retired_count(a_ret), .state(a_state)
  );

  run_controller #(.TIMEOUT_CYCLES(20)) dut_b (
    .clk(clk), .reset(reset), .start(start), .wb_valid(wb_valid), .wb_opcode(wb_opcode),
    .cpu_reset(b_cr), .running(b_run), .done(b_done), .timed_out(b_to),
    .cycle_count(b_cyc), .retired_count(b_ret), .state(b_state)
  );

  run_controller #(.CNT_W(4), .RESET_CYCLES(1), .DRAIN_CYCLES(0)) dut_c (
    .clk(clk), .reset(reset), .start(start), .wb_valid(wb_valid), .wb_opcode(wb_opcode),
    .cpu_reset(c_cr), .running(c_run), .done(c_done), .timed_out(c_to),
    .cycle_count(c_cyc), .retired_count(c_ret), .state(c_state)
  );

  // ---------------- reference model ----------------
  // ph: 0 idle, 1 hold, 2 run, 3 drain, 4 done, 5 timeout; age = edges spent in the phase.
  typedef struct {
    int     ph;
    int     age;
    longint cyc;
    longint ret;
  } mdl_t;

  mdl_t m[3];

  function automatic longint sat_add(longint x, int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (x + 1 > mx) ? mx : x + 1;
  endfunction

  function automatic mdl_t step(mdl_t cur, int i, logic st, logic v, logic [5:0] op);
    mdl_t n;
    n = cur;
    case (cur.ph)
      0, 4, 5: if (st) begin
        n.ph = 1; n.age = 0; n.cyc = 0; n.ret = 0;
      end
      1: begin
        n.age = cur.age + 1;
        if (n.age == cfg_r[i]) begin n.ph = 2; n.age = 0; end
      end
      2: begin
        n.cyc = sat_add(cur.cyc, cfg_w[i]);
        if (v) n.ret = sat_add(cur.ret, cfg_w[i]);
        n.age = cur.age + 1;
        if (v && op == HALT) begin
          n.ph  = (cfg_d[i] > 0) ? 3 : 4;
          n.age = 0;
        end else if (cfg_to[i] > 0 && n.age == cfg_to[i]) begin
          n.ph = 5;
        end
      end
      3: begin
        n.cyc = sat_add(cur.cyc, cfg_w[i]);
        if (v) n.ret = sat_add(cur.ret, cfg_w[i]);
        n.age = cur.age + 1;
        if (n.age == cfg_d[i]) n.ph = 4;
      end
      default: n.ph = 0;
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) m[i] <= '{ph: 0, age: 0, cyc: 0, ret: 0};
    end else begin
      for (int i = 0; i < 3; i++) m[i] <= step(m[i], i, start, wb_valid, wb_opcode);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_dut(input string nm, input int i, input logic [2:0] s,
                           input logic cr, input logic rn, input logic dn, input logic to,
                           input logic [31:0] cc, input logic [31:0] rc);
    mdl_t e;
    logic act;
    e   = m[i];
    act = (e.ph == 2) || (e.ph == 3);
    check({nm, ".state"},     64'(s),  64'(e.ph));
    check({nm, ".cpu_reset"}, 64'(cr), 64'(!act));
    check({nm, ".running"},   64'(rn), 64'(act));
    check({nm, ".done"},      64'(dn), 64'(e.ph == 4));
    check({nm, ".timed_out"}, 64'(to), 64'(e.ph == 5));
    check({nm, ".cycles"},    64'(cc), 64'(e.cyc));
    check({nm, ".retired"},   64'(rc), 64'(e.ret));
  endtask

  task automatic check_all();
    check_dut("A", 0, a_state, a_cr, a_run, a_done, a_to, a_cyc, a_ret);
    check_dut("B", 1, b_state, b_cr, b_run, b_done, b_to, b_cyc, b_ret);
    check_dut("C", 2, c_state, c_cr, c_run, c_done, c_to, 32'(c_cyc), 32'(c_ret));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change just after a falling edge; outputs are compared at the next falling edge.
  task automatic drive(input logic st, input logic v, input logic [5:0] op);
    start = st; wb_valid = v; wb_opcode = op;
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [5:0] non_halt_op();
    return 6'($urandom_range(0, 15));
  endfunction

  function automatic logic model_any_run();
    return (m[0].ph == 2) || (m[1].ph == 2) || (m[2].ph == 2);
  endfunction

  function automatic logic model_settled();
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) if (m[i].ph inside {1, 2, 3}) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic dut_settled();
    return (a_state inside {3'd0, 3'd4, 3'd5}) && (b_state inside {3'd0, 3'd4, 3'd5}) &&
           (c_state inside {3'd0, 3'd4, 3'd5});
  endfunction

  // Retire halts until every configuration has finished its run, within a cycle budget.
  task automatic quiesce();
    int k;
    k = 0;
    while (!model_settled() && k < 60) begin
      drive(1'b0, model_any_run(), HALT);
      k++;
    end
    check("quiesce_settled", 64'(dut_settled()), 64'(1));
    drive(1'b0, 1'b0, 6'h00);
  endtask

  // Called right after a falling edge: pulses reset entirely between clock edges.
  task automatic pulse_reset(input logic directed);
    #2 reset = 1'b0;
    #1;
    if (directed) begin
      check("async_rst.state",     64'(a_state), 64'(0));
      check("async_rst.cpu_reset", 64'(a_cr),    64'(1));
      check("async_rst.running",   64'(a_run),   64'(0));
      check("async_rst.cycles",    64'(a_cyc),   64'(0));
      check("async_rst.retired",   64'(a_ret),   64'(0));
    end
    #1 reset = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    #1 reset = 1'b0;
    #2;
    check("rst.state",     64'(a_state), 64'(0));
    check("rst.cpu_reset", 64'(a_cr),    64'(1));
    check("rst.done",      64'(a_done),  64'(0));
    check("rst.timed_out", 64'(a_to),    64'(0));
    check("rst.cycles",    64'(a_cyc),   64'(0));
    check("rst.retired",   64'(a_ret),   64'(0));
    @(negedge clk);
    check_all();
    #2 reset = 1'b1;

    // Basic run: 10 ordinary retires then a halt.
    drive(1'b1, 1'b0, 6'h00);
    check("basic.hold0_cpu_reset", 64'(a_cr), 64'(1));
    drive(1'b0, 1'b0, 6'h00);
    check("basic.hold1_cpu_reset", 64'(a_cr), 64'(1));
    drive(1'b0, 1'b0, 6'h00);
    check("basic.run_cpu_reset", 64'(a_cr),    64'(0));
    check("basic.run_state",     64'(a_state), 64'(2));
    for (int k = 0; k < 10; k++) drive(1'b0, 1'b1, 6'h00);
    drive(1'b0, 1'b1, HALT);
    check("basic.drain_state", 64'(a_state), 64'(3));
    check("basic.retired",     64'(a_ret),   64'(11));
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 6'h00);
    check("basic.done_early", 64'(a_done), 64'(0));
    drive(1'b0, 1'b0, 6'h00);
    check("basic.done",   64'(a_done), 64'(1));
    check("basic.cycles", 64'(a_cyc),  64'(15));

    // Restart from DONE; start pulses during RUN must be ignored; invalid halt must not end the run.
    drive(1'b1, 1'b0, 6'h00);
    check("restart.cycles_clr",  64'(a_cyc),   64'(0));
    check("restart.retired_clr", 64'(a_ret),   64'(0));
    check("restart.hold_state",  64'(a_state), 64'(1));
    drive(1'b0, 1'b0, 6'h00);
    check("restart.hold1_state", 64'(a_state), 64'(1));
    drive(1'b0, 1'b0, 6'h00);
    check("restart.run_state", 64'(a_state), 64'(2));
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, 6'h00);
    check("restart.start_ignored", 64'(a_state), 64'(2));
    check("restart.retired",       64'(a_ret),   64'(5));
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, HALT);
    check("inv_halt.state",   64'(a_state), 64'(2));
    check("inv_halt.retired", 64'(a_ret),   64'(5));
    check("inv_halt.cycles",  64'(a_cyc),   64'(8));
    quiesce();

    // Watchdog expiry on configuration B.
    drive(1'b1, 1'b0, 6'h00);
    for (int k = 0; k < 21; k++) drive(1'b0, 1'($urandom_range(0, 1)), non_halt_op());
    check("timeout.not_yet", 64'(b_state), 64'(2));
    drive(1'b0, 1'($urandom_range(0, 1)), non_halt_op());
    check("timeout.state",     64'(b_state), 64'(5));
    check("timeout.timed_out", 64'(b_to),    64'(1));
    check("timeout.cycles",    64'(b_cyc),   64'(20));
    check("timeout.cpu_reset", 64'(b_cr),    64'(1));
    check("timeout.done",      64'(b_done),  64'(0));
    quiesce();

    // Halt retiring on the last watchdog cycle wins.
    drive(1'b1, 1'b0, 6'h00);
    for (int k = 0; k < 21; k++) drive(1'b0, 1'b0, non_halt_op());
    drive(1'b0, 1'b1, HALT);
    check("sim_halt.drain", 64'(b_state), 64'(3));
    check("sim_halt.to",    64'(b_to),    64'(0));
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 6'h00);
    check("sim_halt.done",  64'(b_done), 64'(1));
    check("sim_halt.to2",   64'(b_to),   64'(0));
    quiesce();

    // Saturation on configuration C: 20 retires into a 4-bit counter.
    drive(1'b1, 1'b0, 6'h00);
    drive(1'b0, 1'b0, 6'h00);
    for (int k = 0; k < 20; k++) drive(1'b0, 1'b1, 6'h00);
    drive(1'b0, 1'b1, HALT);
    check("sat.retired", 64'(c_ret),   64'(15));
    check("sat.cycles",  64'(c_cyc),   64'(15));
    check("sat.state",   64'(c_state), 64'(4));
    quiesce();

    // Asynchronous reset while A is draining.
    drive(1'b1, 1'b0, 6'h00);
    drive(1'b0, 1'b0, 6'h00);
    drive(1'b0, 1'b0, 6'h00);
    drive(1'b0, 1'b1, HALT);
    drive(1'b0, 1'b0, 6'h00);
    check("async_rst.pre_drain", 64'(a_state), 64'(3));
    pulse_reset(1'b1);
    drive(1'b0, 1'b0, 6'h00);

    // Randomised traffic with occasional asynchronous resets.
    for (int k = 0; k < 400; k++) begin
      logic       st, v;
      logic [5:0] op;
      st = ($urandom_range(0, 7) == 0);
      v  = 1'($urandom_range(0, 1));
      op = ($urandom_range(0, 11) == 0) ? HALT : 6'($urandom_range(0, 63));
      drive(st, v, op);
      if ($urandom_range(0, 149) == 0) pulse_reset(1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
- Synthesizable run-control block that sequences the processor's reset, counts cycles and retired instructions, and detects program end from the write-back stage.
- Generalises the fixed halt-opcode check to a configurable opcode, a pipeline-drain window, a timeout watchdog and restartable runs.
- Sits beside the Processor. Drives its active-high reset. Observes write-back valid and opcode.

Parameters:
- OPCODE_W, 6, width of write-back opcode field
- HALT_OPCODE, 6'h11, opcode that ends a run
- RESET_CYCLES, 2, cycles cpu_reset is held high at run start (legal range 1..255)
- DRAIN_CYCLES, 4, cycles after halt retire before done (0 allowed)
- TIMEOUT_CYCLES, 100000, RUN-state cycles before timeout (0 disables watchdog)
- CNT_W, 32, width of cycle and retire counters

Ports:
- clk  in  1  sole clock, all state on rising edge
- reset  in  1  asynchronous, active-low block reset
- start  in  1  pulse; begins a run from IDLE, DONE or TIMEOUT
- wb_valid  in  1  write-back stage retires an instruction this cycle
- wb_opcode  in  OPCODE_W  opcode of retiring instruction
- cpu_reset  out  1  active-high reset to Processor
- running  out  1  high in RUN and DRAIN
- done  out  1  high in DONE (halt seen, drain complete)
- timed_out  out  1  high in TIMEOUT
- cycle_count  out  CNT_W  cycles spent in RUN+DRAIN this run
- retired_count  out  CNT_W  instructions retired this run, halt included
- state  out  3  encoded FSM state for debug

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, cpu_reset=1, running=0, done=0, timed_out=0.
  - Both counters=0. Internal timers=0.
- States and encoding: IDLE=0, HOLD=1, RUN=2, DRAIN=3, DONE=4, TIMEOUT=5.
- IDLE:
  - cpu_reset=1.
  - start=1 -> HOLD; counters cleared on the same edge.
- HOLD:
  - cpu_reset=1 for exactly RESET_CYCLES cycles, counted from entry, then -> RUN.
  - wb_valid is ignored in HOLD.
- RUN:
  - cpu_reset=0.
  - cycle_count increments every cycle.
  - retired_count increments on every cycle with wb_valid=1.
  - wb_valid=1 with wb_opcode==HALT_OPCODE -> DRAIN if DRAIN_CYCLES>0, else -> DONE. That halt instruction is counted.
  - Watchdog: when TIMEOUT_CYCLES>0 and the RUN-cycle timer reaches TIMEOUT_CYCLES-1 without a halt -> TIMEOUT.
  - Halt retire and timeout expiry in the same cycle: halt wins.
- DRAIN:
  - cpu_reset=0.
  - cycle_count keeps incrementing. retired_count still counts wb_valid.
  - Further halt opcodes are ignored.
  - -> DONE after DRAIN_CYCLES cycles. No watchdog in DRAIN.
- DONE / TIMEOUT:
  - cpu_reset=1 (processor frozen).
  - Counters hold their final values. done or timed_out held high.
  - start=1 -> HOLD with counters cleared: a restart.
- start is ignored in HOLD, RUN and DRAIN.
- Outputs are registered. done and timed_out rise one cycle after the decisive edge input is sampled.
- Counters saturate at all-ones and do not wrap. The watchdog timer uses the same saturating width.
- Mid-operation reset: returns to IDLE immediately, irrespective of state. The cpu_reset assertion is asynchronous with reset.
- wb_opcode is don't-care when wb_valid=0; a halt opcode without valid must not end the run.

Decomposition:
- Shared package run_ctrl_pkg holds:
  - the state enum/localparams (IDLE..TIMEOUT)
  - the default HALT_OPCODE constant, shared with the decode stage's opcode definitions
- One natural sub-module, sat_counter (param WIDTH; inputs clr, inc; output count, saturating). Instantiated for cycle_count, retired_count and the watchdog/hold/drain timer.

Test Plan:
- Basic run:
  - Stimulus: reset low, release; start pulse; 10 retires (one per cycle) with opcode 6'h00, then one with 6'h11.
  - Required: cpu_reset high for exactly 2 cycles after start; retired_count=11; done high 4 cycles after the halt retire; cycle_count=15.
- Invalid halt:
  - Stimulus: wb_opcode=6'h11 with wb_valid=0 during RUN.
  - Required: remains in RUN (state=2), retired_count unchanged.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=20, no halt.
  - Required: timed_out high after 20 RUN cycles; cycle_count=20; cpu_reset=1; done=0.
- Simultaneous halt and timeout:
  - Stimulus: TIMEOUT_CYCLES=20, halt retires on RUN cycle 20.
  - Required: DRAIN then DONE; timed_out stays 0.
- Restart:
  - Stimulus: start pulse in DONE.
  - Required: counters read 0 the cycle after; HOLD 2 cycles; second run counts independently. Extra start pulses during RUN are ignored.
- Async reset mid-DRAIN:
  - Stimulus: reset low between clock edges.
  - Required: state=0, cpu_reset=1, counters=0 before the next clk edge.
- Saturation:
  - Stimulus: CNT_W=4, 20 retires.
  - Required: retired_count=15, no wrap.
